ad_spi_responder: RTL
=====================

# ad_spi_responder

Synthesizable model of the 2-channel, 10-bit SPI A/D converter that the AD controller talks to. It sits on the far side of the SCK/SDIN/CSLD/SDOUT link: it decodes the controller's start and configuration bits, latches a channel value and shifts the 10-bit result back. Test benches use it in place of the physical converter, and it can also be placed on the FPGA for loop-back bring-up. All pins are oversampled by the system clock; there is no logic clocked by SCK.

## Interface
- SYNC_STAGES, 2: synchronizer depth on SCK, SDIN, CSLD (≥2)
- DATA_W, 10: conversion result width
- CLK  in  1  system clock, all flops rising edge
- RST  in  1  synchronous, active-high reset
- SCK  in  1  serial clock from controller, idle low
- SDIN  in  1  command data from controller, sampled on SCK rise
- CSLD  in  1  chip select, active low
- SDOUT  out  1  result data to controller, changes on SCK fall
- ch0  in  DATA_W  analog value for channel 0 (unsigned)
- ch1  in  DATA_W  analog value for channel 1 (unsigned)
- conv_done  out  1  one-CLK pulse when last result bit is driven
- conv_cfg  out  3  {SGL, ODD, MSBF} of the last accepted frame

## Operation
- SCK, SDIN, CSLD each pass through SYNC_STAGES flops; edges are detected on the synchronized SCK by comparing against one extra delay flop.
- States: IDLE, WAIT_START, CFG, NULLB, DATA, LSBF, DONE.
- IDLE: SDOUT=0. Synchronized CSLD low → WAIT_START.
- WAIT_START: SCK rise with SDIN=0 is ignored (leading zeros are allowed). SCK rise with SDIN=1 → CFG, cfg bit count=0.
- CFG: three SCK rises shift in SGL, ODD, MSBF in that order. On the third rise, latch the sample value, update conv_cfg, → NULLB.
- Sample value: SGL=1 gives ODD? ch1 : ch0. SGL=0 and ODD=0 gives ch0−ch1, clamped to 0 when negative. SGL=0 and ODD=1 gives ch1−ch0, clamped the same way. Subtraction is DATA_W+1 bits wide and the result is DATA_W bits.
- NULLB: on the next SCK fall, drive SDOUT=0 (the null bit) and go to DATA with bit index = DATA_W−1.
- DATA: each SCK fall drives sample[index], then decrements the index. After sample[0] is driven:
  - MSBF=1: pulse conv_done and go to DONE.
  - MSBF=0: go to LSBF with index=1.
- LSBF: each SCK fall drives sample[index], then increments the index. After sample[DATA_W−1] is driven, pulse conv_done and go to DONE. This repeats the result LSB-first without re-sending bit 0.
- DONE: SDOUT=0 on every following SCK fall. SCK edges are otherwise ignored.
- Synchronized CSLD high in any state → IDLE on the next CLK and SDOUT=0. The frame aborts, conv_done is not pulsed, and conv_cfg keeps the value it already holds.
- SCK edges are ignored while synchronized CSLD is high.

## Timing
- Reset values: SDOUT=0, conv_done=0, conv_cfg=3'b000, state IDLE, synchronizers and the sample register cleared.
- Pin-to-detect latency: a pin edge is recognized SYNC_STAGES+1 CLK cycles after it occurs. SDOUT updates on the CLK edge that recognizes the SCK fall, so SDOUT lags the SCK fall by SYNC_STAGES+1 CLK.
- The controller must keep each SCK half-period at ≥ SYNC_STAGES+3 CLK. This lets SDOUT settle before the next SCK rise.
- CSLD must fall ≥ SYNC_STAGES+1 CLK before the first SCK rise.
- conv_done is high for exactly one CLK, on the same CLK edge that drives the final bit.
- ch0/ch1 are sampled once, on the CLK cycle that recognizes the MSBF rise. Later changes do not affect the frame in progress.
- If RST is asserted mid-frame, on the next CLK edge every output returns to its reset value. The responder then waits in IDLE for a fresh CSLD fall, even if CSLD is still low.

## Test plan
- Single-ended channel 0: ch0=10'h2A5, frame 1,1,0,1 → SDOUT bits after the null are 1010100101, one conv_done, conv_cfg=3'b101.
- Single-ended channel 1, LSB-first tail: ch1=10'h301, frame 1,1,1,0 → 1100000001 followed by 000000011, conv_done only after the last bit, conv_cfg=3'b110.
- Differential with clamping:
  - ch0=10'd100, ch1=10'd40, frame SGL=0 ODD=0 → result 10'd60.
  - Same inputs with ODD=1 → result 10'd0.
- Leading zeros and input change: three SDIN=0 clocks before the start bit are ignored. ch0 changed after the MSBF rise → result still reflects the latched value.
- Abort: raise CSLD after 4 data bits → SDOUT=0 within SYNC_STAGES+1 CLK, no conv_done. The next full frame is correct.
- Reset mid-DATA: assert RST for 1 CLK → SDOUT=0, conv_cfg=0. SCK edges are ignored until CSLD goes high, then low again.

Source files
------------

// File: rtl/ad_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ad_spi_responder
//  Description : Behavioural stand-in for a 2-channel, 10-bit SPI A/D
//                converter. It decodes the controller's start and
//                configuration bits, latches a channel value (single-ended
//                or clamped differential) and shifts the result back on
//                SDOUT. The bits go out MSB-first and can optionally repeat
//                LSB-first. All pins are oversampled by CLK. No logic is
//                clocked by SCK.
//  Ports       : CLK, RST      - system clock, synchronous active-high reset
//                SCK/SDIN/CSLD - serial clock, command data, chip select (low)
//                SDOUT         - result data, updated on recognised SCK fall
//                ch0, ch1      - channel values (unsigned, DATA_W bits)
//                conv_done     - one-CLK pulse with the final result bit
//                conv_cfg      - {SGL, ODD, MSBF} of the last accepted frame
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCK,
    input  logic              SDIN,
    input  logic              CSLD,
    output logic              SDOUT,
    input  logic [DATA_W-1:0] ch0,
    input  logic [DATA_W-1:0] ch1,
    output logic              conv_done,
    output logic [2:0]        conv_cfg
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_CFG        = 3'd2,
        S_NULLB      = 3'd3,
        S_DATA       = 3'd4,
        S_LSBF       = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdin_sync;
    logic [SYNC_STAGES-1:0] r_csld_sync;
    logic                   r_sck_dly;
    logic                   r_armed;
    state_t                 r_state;
    logic [1:0]             r_cfg_cnt;
    logic [1:0]             r_cfg_sh;
    logic                   r_msbf;
    logic [DATA_W-1:0]      r_sample;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_sdout;
    logic                   r_done;
    logic [2:0]             r_cfg;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                 w_state;
    logic [1:0]             w_cfg_cnt;
    logic [1:0]             w_cfg_sh;
    logic                   w_msbf;
    logic [DATA_W-1:0]      w_sample;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_sdout;
    logic                   w_done;
    logic [2:0]             w_cfg;

    logic                   w_sck_s;
    logic                   w_sdin_s;
    logic                   w_csld_s;
    logic                   w_rise;
    logic                   w_fall;
    logic [DATA_W:0]        w_diff;
    logic [DATA_W-1:0]      w_sel_val;

    assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
    assign w_sdin_s = r_sdin_sync[SYNC_STAGES-1];
    assign w_csld_s = r_csld_sync[SYNC_STAGES-1];

    // Edges only count while selected. The deselected case is handled by
    // the forced return to IDLE anyway.
    assign w_rise = w_sck_s & ~r_sck_dly & ~w_csld_s;
    assign w_fall = ~w_sck_s & r_sck_dly & ~w_csld_s;

    // Sample selection uses SGL/ODD held in the shift register. It is only
    // consumed on the MSBF rise, when both bits are already in place.
    // The subtraction is one bit wider than the channels, so the top bit
    // flags a negative difference, which is clamped to zero.
    always_comb begin
        w_diff    = '0;
        w_sel_val = '0;
        if (r_cfg_sh[1]) begin
            w_sel_val = r_cfg_sh[0] ? ch1 : ch0;
        end else begin
            if (r_cfg_sh[0]) begin
                w_diff = {1'b0, ch1} - {1'b0, ch0};
            end else begin
                w_diff = {1'b0, ch0} - {1'b0, ch1};
            end
            w_sel_val = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Synchronisers, edge-detect delay and the reset re-arm flag
    // ------------------------------------------------------------------
    // r_armed stays low after reset until CSLD has been seen high. This
    // makes a reset in mid-frame wait for a fresh CSLD fall. The cleared
    // CSLD synchroniser would otherwise look like an active select.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sck_sync  <= '0;
            r_sdin_sync <= '0;
            r_csld_sync <= '0;
            r_sck_dly   <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
            r_sdin_sync <= {r_sdin_sync[SYNC_STAGES-2:0], SDIN};
            r_csld_sync <= {r_csld_sync[SYNC_STAGES-2:0], CSLD};
            r_sck_dly   <= w_sck_s;
            if (w_csld_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cfg_cnt <= 2'd0;
            r_cfg_sh  <= 2'b00;
            r_msbf    <= 1'b0;
            r_sample  <= '0;
            r_idx     <= '0;
            r_sdout   <= 1'b0;
            r_done    <= 1'b0;
            r_cfg     <= 3'b000;
        end else begin
            r_state   <= w_state;
            r_cfg_cnt <= w_cfg_cnt;
            r_cfg_sh  <= w_cfg_sh;
            r_msbf    <= w_msbf;
            r_sample  <= w_sample;
            r_idx     <= w_idx;
            r_sdout   <= w_sdout;
            r_done    <= w_done;
            r_cfg     <= w_cfg;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state   = r_state;
        w_cfg_cnt = r_cfg_cnt;
        w_cfg_sh  = r_cfg_sh;
        w_msbf    = r_msbf;
        w_sample  = r_sample;
        w_idx     = r_idx;
        w_sdout   = r_sdout;
        w_done    = 1'b0;
        w_cfg     = r_cfg;

        if (w_csld_s) begin
            // Deselect aborts any frame. conv_cfg keeps its last value.
            w_state = S_IDLE;
            w_sdout = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sdout = 1'b0;
                    if (r_armed) begin
                        w_state = S_WAIT_START;
                    end
                end

                S_WAIT_START: begin
                    // Leading zeros are skipped until the start bit.
                    if (w_rise && w_sdin_s) begin
                        w_state   = S_CFG;
                        w_cfg_cnt = 2'd0;
                    end
                end

                S_CFG: begin
                    if (w_rise) begin
                        if (r_cfg_cnt == 2'd2) begin
                            w_sample = w_sel_val;
                            w_msbf   = w_sdin_s;
                            w_cfg    = {r_cfg_sh, w_sdin_s};
                            w_state  = S_NULLB;
                        end else begin
                            w_cfg_sh  = {r_cfg_sh[0], w_sdin_s};
                            w_cfg_cnt = r_cfg_cnt + 2'd1;
                        end
                    end
                end

                S_NULLB: begin
                    if (w_fall) begin
                        w_sdout = 1'b0;
                        w_idx   = IDX_W'(DATA_W - 1);
                        w_state = S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_fall) begin
                        w_sdout = r_sample[r_idx];
                        if (r_idx == '0) begin
                            if (r_msbf) begin
                                w_done  = 1'b1;
                                w_state = S_DONE;
                            end else begin
                                // Bit 0 is shared between both halves.
                                w_idx   = IDX_W'(1);
                                w_state = S_LSBF;
                            end
                        end else begin
                            w_idx = r_idx - IDX_W'(1);
                        end
                    end
                end

                S_LSBF: begin
                    if (w_fall) begin
                        w_sdout = r_sample[r_idx];
                        if (r_idx == IDX_W'(DATA_W - 1)) begin
                            w_done  = 1'b1;
                            w_state = S_DONE;
                        end else begin
                            w_idx = r_idx + IDX_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    if (w_fall) begin
                        w_sdout = 1'b0;
                    end
                end

                default: begin
                    w_state = S_IDLE;
                    w_sdout = 1'b0;
                end
            endcase
        end
    end

    assign SDOUT     = r_sdout;
    assign conv_done = r_done;
    assign conv_cfg  = r_cfg;

endmodule
`default_nettype wire
